alu_pipe_param: RTL and testbench

//  Parametrised, pipelined successor of the single-cycle WISC ALU. Executes the same 16

---
 rtl/alu_pipe_if.sv | 25 ++
 rtl/alu_pipe_param.sv | 161 ++++++++++++++++
 tb/tb_alu_pipe_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle between the decode/regfile side, the pipelined ALU and
// writeback: operation request channel, result channel and the flag file.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [2:0]       flags;

  modport master (
    output in_valid, opcode, alu_in1, alu_in2, out_ready,
    input  in_ready, out_valid, alu_out, flags
  );

  modport slave (
    input  in_valid, opcode, alu_in1, alu_in2, out_ready,
    output in_ready, out_valid, alu_out, flags
  );
endinterface

// File: rtl/alu_pipe_param.sv
// Pipelined, parametrised WISC ALU. It executes the 16 opcodes on WIDTH-bit
// operands behind a valid/ready handshake. ADD, SUB and PADDSB saturate, and
// RED sums the bytes of both operands. A registered {N,Z,V} flag file uses a
// per-opcode write mask.
// Build option: define ALU_OUT_REG_EN to insert a compute register between the
// operand stage and alu_out (latency 2, bubble-collapsing). Leave it undefined
// to register the compute result directly into alu_out (latency 1).
module alu_pipe_param #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] FULL_SH = (SHW + 1)'(WIDTH);

  // One op in flight: the result, the flag values it would produce, and which
  // flag bits it is allowed to write.
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             n;
    logic             z;
    logic             v;
    logic             wr_nv;
    logic             wr_z;
  } stage_t;

  // Signed add/sub with clamp to the most positive/negative value.
  // Returns {overflowed, result}.
  function automatic logic [WIDTH:0] sat_addsub(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b,
                                                input logic                    sub);
    logic signed [WIDTH:0] full;
    full = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
               : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
    if (full[WIDTH] != full[WIDTH-1])
      return {1'b1, full[WIDTH], {(WIDTH-1){~full[WIDTH]}}};
    return {1'b0, full[WIDTH-1:0]};
  endfunction

  // One signed nibble lane that saturates to 7 / -8.
  function automatic logic [3:0] sat_lane4(input logic signed [3:0] a,
                                           input logic signed [3:0] b);
    logic signed [4:0] s;
    s = {a[3], a} + {b[3], b};
    if (s[4] != s[3])
      return s[4] ? 4'h8 : 4'h7;
    return s[3:0];
  endfunction

  // Add in independent nibble lanes. No carry crosses a lane boundary.
  function automatic logic [WIDTH-1:0] paddsb(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH / 4; i++)
      r[4*i +: 4] = sat_lane4(a[4*i +: 4], b[4*i +: 4]);
    return r;
  endfunction

  // Signed sum of every byte of both operands. The accumulator is wide enough
  // that this cannot overflow for WIDTH >= 16.
  function automatic logic [WIDTH-1:0] red_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      acc = acc + {{(WIDTH-8){a[8*i+7]}}, a[8*i +: 8]};
      acc = acc + {{(WIDTH-8){b[8*i+7]}}, b[8*i +: 8]};
    end
    return acc;
  endfunction

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic [SHW-1:0]          amt_p0;
  logic [WIDTH:0]          sat_p0;
  stage_t                  cmp_p0;

  assign a_p0   = $signed(bus.alu_in1);
  assign b_p0   = $signed(bus.alu_in2);
  assign amt_p0 = bus.alu_in2[SHW-1:0];
  assign sat_p0 = sat_addsub(a_p0, b_p0, bus.opcode[0]);

  // ---- p0: operand stage, combinational compute and flag write mask ----
  always_comb begin
    cmp_p0 = '0;
    unique case (bus.opcode)
      4'h0, 4'h1: begin
        cmp_p0.res   = sat_p0[WIDTH-1:0];
        cmp_p0.v     = sat_p0[WIDTH];
        cmp_p0.wr_nv = 1'b1;
        cmp_p0.wr_z  = 1'b1;
      end
      4'h2: begin cmp_p0.res = a_p0 ^ b_p0;                    cmp_p0.wr_z = 1'b1; end
      4'h3: begin cmp_p0.res = red_sum(bus.alu_in1, bus.alu_in2); cmp_p0.wr_z = 1'b1; end
      4'h4: begin cmp_p0.res = bus.alu_in1 << amt_p0;           cmp_p0.wr_z = 1'b1; end
      4'h5: begin cmp_p0.res = a_p0 >>> amt_p0;                 cmp_p0.wr_z = 1'b1; end
      4'h6: begin
        cmp_p0.res  = (bus.alu_in1 >> amt_p0) |
                      (bus.alu_in1 << (FULL_SH - {1'b0, amt_p0}));
        cmp_p0.wr_z = 1'b1;
      end
      4'h7: begin cmp_p0.res = paddsb(bus.alu_in1, bus.alu_in2); cmp_p0.wr_z = 1'b1; end
      4'h8, 4'h9: cmp_p0.res = bus.alu_in1 + bus.alu_in2;
      default:    cmp_p0.res = bus.alu_in1 | bus.alu_in2;
    endcase
    cmp_p0.n = cmp_p0.res[WIDTH-1];
    cmp_p0.z = (cmp_p0.res == '0);
  end

  logic   adv_out;
  logic   src_vld;
  stage_t src;

  assign adv_out = !bus.out_valid || bus.out_ready;

`ifdef ALU_OUT_REG_EN
  // ---- p1: compute register ----
  stage_t st_p1;
  logic   vld_p1;

  assign bus.in_ready = !vld_p1 || adv_out;

  // Compute-stage valid: refill whenever the stage is empty or draining.
  always_ff @(posedge clk) begin
    if (rst)               vld_p1 <= 1'b0;
    else if (bus.in_ready) vld_p1 <= bus.in_valid;
  end

  // Compute-stage payload: only meaningful while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (bus.in_ready && bus.in_valid) st_p1 <= cmp_p0;
  end

  assign src_vld = vld_p1;
  assign src     = st_p1;
`else
  assign bus.in_ready = adv_out;
  assign src_vld      = bus.in_valid;
  assign src          = cmp_p0;
`endif

  // ---- output stage: alu_out and flags load on the same edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.alu_out   <= '0;
      bus.flags     <= 3'b000;
    end else if (adv_out) begin
      bus.out_valid <= src_vld;
      if (src_vld) begin
        bus.alu_out <= src.res;
        bus.flags   <= {src.wr_nv ? src.n : bus.flags[2],
                        src.wr_z  ? src.z : bus.flags[1],
                        src.wr_nv ? src.v : bus.flags[0]};
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed bench for alu_pipe_param at WIDTH=16: table of single ops with
// hand-computed results and cumulative flags, then backpressure streaming and
// mid-traffic reset sequences.
module tb_alu_pipe_param;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic [2:0]  exp_fl;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=timeout required=handshake", name);
  endtask

  // Present one op and hold it until the DUT accepts it.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      output bit ok);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.alu_in1  = a;
    bus.alu_in2  = b;
    n = 0;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (n < 20);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait, bounded, for the next presented result.
  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    ok = bus.out_valid;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    int idx, got, stall;
    bit saw_full;
    logic [15:0] rec_out;
    logic [2:0]  rec_fl;
    logic [15:0] bp_a   [4] = '{16'h0001, 16'h7000, 16'h0000, 16'h8000};
    logic [15:0] bp_b   [4] = '{16'h0001, 16'h7000, 16'h0000, 16'hFFFF};
    logic [15:0] bp_out [4] = '{16'h0002, 16'h7FFF, 16'h0000, 16'h8000};
    logic [2:0]  bp_fl  [4] = '{3'b000, 3'b001, 3'b010, 3'b101};

    vecs[0]  = '{4'h0, 16'h7FF0, 16'h0020, 16'h7FFF, 3'b001};
    vecs[1]  = '{4'h1, 16'h8000, 16'h0001, 16'h8000, 3'b101};
    vecs[2]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 3'b010};
    vecs[3]  = '{4'h2, 16'h00F0, 16'h0F00, 16'h0FF0, 3'b000};
    vecs[4]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 3'b010};
    vecs[5]  = '{4'h1, 16'h8000, 16'h0001, 16'h8000, 3'b101};
    vecs[6]  = '{4'h7, 16'h7878, 16'h1188, 16'h79F8, 3'b101};
    vecs[7]  = '{4'h3, 16'h7F7F, 16'h7F7F, 16'h01FC, 3'b101};
    vecs[8]  = '{4'h6, 16'h8001, 16'h0001, 16'hC000, 3'b101};
    vecs[9]  = '{4'h5, 16'h8000, 16'h000F, 16'hFFFF, 3'b101};
    vecs[10] = '{4'h4, 16'h1234, 16'h0000, 16'h1234, 3'b101};
    vecs[11] = '{4'h4, 16'h0001, 16'h0011, 16'h0002, 3'b101};
    vecs[12] = '{4'h4, 16'h8000, 16'h0001, 16'h0000, 3'b111};
    vecs[13] = '{4'h8, 16'h7FFF, 16'h0001, 16'h8000, 3'b111};
    vecs[14] = '{4'h9, 16'hFFFF, 16'h0002, 16'h0001, 3'b111};
    vecs[15] = '{4'hA, 16'h00F0, 16'h0F0F, 16'h0FFF, 3'b111};
    vecs[16] = '{4'hF, 16'h0000, 16'h0000, 16'h0000, 3'b111};
    vecs[17] = '{4'h3, 16'h0080, 16'h0000, 16'hFF80, 3'b101};
    vecs[18] = '{4'h0, 16'h8000, 16'h8000, 16'h8000, 3'b101};
    vecs[19] = '{4'h0, 16'h0001, 16'h0002, 16'h0003, 3'b000};
    vecs[20] = '{4'h7, 16'h9999, 16'h9999, 16'h8888, 3'b000};
    vecs[21] = '{4'h6, 16'h1234, 16'h0004, 16'h4123, 3'b000};
    vecs[22] = '{4'h5, 16'h4000, 16'h0002, 16'h1000, 3'b000};
    vecs[23] = '{4'h3, 16'h0102, 16'h0304, 16'h000A, 3'b000};
    vecs[24] = '{4'h1, 16'h0003, 16'h0005, 16'hFFFE, 3'b100};
    vecs[25] = '{4'h2, 16'h1234, 16'h1234, 16'h0000, 3'b110};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = 4'h0;
    bus.alu_in1   = '0;
    bus.alu_in2   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 16'(bus.out_valid), 16'h0);
    chk("reset_alu_out",   bus.alu_out,        16'h0);
    chk("reset_flags",     16'(bus.flags),     16'h0);
    chk("reset_in_ready",  16'(bus.in_ready),  16'h1);

    // Table: one op at a time, flags accumulate across entries.
    for (int i = 0; i < 26; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, ok);
      if (!ok) timeout($sformatf("v%0d_accept", i));
      wait_out(ok);
      if (!ok) timeout($sformatf("v%0d_result", i));
      else begin
        chk($sformatf("v%0d_out", i),   bus.alu_out,    vecs[i].exp_out);
        chk($sformatf("v%0d_flags", i), 16'(bus.flags), 16'(vecs[i].exp_fl));
      end
    end

    // Backpressure: stream 4 ADDs, hold the first result for 3 cycles.
    idx = 0; got = 0; stall = 0; saw_full = 0;
    rec_out = '0; rec_fl = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = (stall >= 3);
      #1;
      if (bus.out_valid && stall < 3) begin
        if (stall == 0) begin
          rec_out = bus.alu_out;
          rec_fl  = bus.flags;
        end else begin
          chk("bp_hold_out",   bus.alu_out,    rec_out);
          chk("bp_hold_flags", 16'(bus.flags), 16'(rec_fl));
        end
        stall++;
      end
      if (!bus.out_ready && !bus.in_ready) saw_full = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp%0d_out", got),   bus.alu_out,    bp_out[got]);
        chk($sformatf("bp%0d_flags", got), 16'(bus.flags), 16'(bp_fl[got]));
        got++;
      end
      if (idx < 4) begin
        bus.in_valid = 1'b1;
        bus.opcode   = 4'h0;
        bus.alu_in1  = bp_a[idx];
        bus.alu_in2  = bp_b[idx];
        if (bus.in_ready) idx++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_result_count", 16'(got), 16'd4);
    chk("bp_in_ready_low", 16'(saw_full), 16'h1);

    // Reset in the middle of stalled traffic.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode   = 4'h1;
      bus.alu_in1  = 16'h8000;
      bus.alu_in2  = 16'h0001 + 16'(c);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_mid_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_mid_alu_out",   bus.alu_out,        16'h0);
    chk("rst_mid_flags",     16'(bus.flags),     16'h0);
    chk("rst_mid_in_ready",  16'(bus.in_ready),  16'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_stale", 16'(bus.out_valid), 16'h0);
    end
    send(4'h0, 16'h0002, 16'h0003, ok);
    if (!ok) timeout("post_rst_accept");
    wait_out(ok);
    if (!ok) timeout("post_rst_result");
    else begin
      chk("post_rst_out",   bus.alu_out,    16'h0005);
      chk("post_rst_flags", 16'(bus.flags), 16'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
